// File: rtl/shift_seq_unit_if.sv
// Request/result bundle for the sequential shifter (shift_seq_unit).
// The control unit drives through "master"; the shifter attaches as "slave".
interface shift_seq_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] shift_src;
   logic [4:0]       shift_amt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, shift_src, shift_amt,
      input  busy, done, result
   );

   modport slave (
      input  start, op, shift_src, shift_amt,
      output busy, done, result
   );
endinterface

// File: rtl/shift_seq_unit.sv
// Sequential one-bit-per-clock 32-bit shifter (SLL/SRL/SRA, op 11 = ROR or pass).
// Define SHIFT_SEQ_ROR_EN to make op 11 rotate-right; otherwise op 11 passes the source through.
module shift_seq_unit #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             reset_n,
   shift_seq_unit_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             load_s;
   logic             step_s;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] work_r;
   logic [4:0]       cnt_r;
   logic             busy_r;
   logic             done_r;

   function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] op_i,
                                                  input logic [WIDTH-1:0] r_i);
      logic [WIDTH-1:0] v;
      case (op_i)
         2'b00:   v = {r_i[WIDTH-2:0], 1'b0};
         2'b01:   v = {1'b0, r_i[WIDTH-1:1]};
         2'b10:   v = {r_i[WIDTH-1], r_i[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROR_EN
         2'b11:   v = {r_i[0], r_i[WIDTH-1:1]};
`else
         2'b11:   v = r_i;
`endif
         default: v = r_i;
      endcase
      return v;
   endfunction

   // Next-state and datapath-control decode
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               load_s      = 1'b1;
               state_nxt_s = (bus.shift_amt == 5'd0) ? ST_DONE : ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            step_s = 1'b1;
            if (cnt_r == 5'd1) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register; busy/done are registered from the next state so they equal state decodes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ST_SHIFT);
         done_r  <= (state_nxt_s == ST_DONE);
      end
   end

   // Operand capture on accepted start, one-bit step per SHIFT cycle; result holds otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_r   <= 2'b00;
         work_r <= {WIDTH{1'b0}};
         cnt_r  <= 5'd0;
      end else if (load_s) begin
         op_r   <= bus.op;
         work_r <= bus.shift_src;
         cnt_r  <= bus.shift_amt;
      end else if (step_s) begin
         work_r <= shift_one(op_r, work_r);
         cnt_r  <= cnt_r - 5'd1;
      end else begin
         op_r   <= op_r;
         work_r <= work_r;
         cnt_r  <= cnt_r;
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = work_r;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed self-checking bench for shift_seq_unit; op 11 expectation follows SHIFT_SEQ_ROR_EN.
module tb_shift_seq_unit;

   logic clk;
   logic reset_n;
   int   err_cnt;
   int   chk_cnt;

   shift_seq_unit_if #(.WIDTH(32)) bus_if ();

   shift_seq_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Launch one op, count busy cycles and the done cycle; optionally pulse start at cycle poke_cyc
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] s,
                         input logic [4:0] a, input logic [31:0] exp, input int poke_cyc);
      int busy_cnt;
      int done_cyc;
      logic [31:0] res_at_done;
      busy_cnt    = 0;
      done_cyc    = 0;
      res_at_done = 32'h0;
      @(posedge clk); #1;
      bus_if.start = 1'b1; bus_if.op = o; bus_if.shift_src = s; bus_if.shift_amt = a;
      @(posedge clk); #1;
      bus_if.start = 1'b0; bus_if.op = ~o; bus_if.shift_src = ~s; bus_if.shift_amt = ~a;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         @(negedge clk);
         if (bus_if.busy) busy_cnt++;
         if (bus_if.done) begin
            done_cyc    = c;
            res_at_done = bus_if.result;
         end
         if (c == poke_cyc) begin
            bus_if.start = 1'b1; bus_if.shift_amt = 5'd1; bus_if.shift_src = 32'hFFFF_FFFF;
         end
         if (c == poke_cyc + 1) bus_if.start = 1'b0;
      end
      bus_if.start = 1'b0;
      check_eq({tag, "_done_cyc"}, done_cyc, 32'(a) + 32'd1);
      check_eq({tag, "_busy_cnt"}, busy_cnt, 32'(a));
      check_eq({tag, "_result"}, res_at_done, exp);
      @(posedge clk); @(negedge clk);
      check_eq({tag, "_done_pulse"}, {31'd0, bus_if.done}, 32'd0);
      check_eq({tag, "_held"}, bus_if.result, exp);
   endtask

   initial begin
      int done_seen;
      err_cnt = 0;
      chk_cnt = 0;
      reset_n = 1'b0;
      bus_if.start = 1'b0; bus_if.op = 2'b00; bus_if.shift_src = 32'h0; bus_if.shift_amt = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check_eq("rst_done", {31'd0, bus_if.done}, 32'd0);
      check_eq("rst_result", bus_if.result, 32'h0);

      // Reset in the middle of a 20-bit shift
      @(posedge clk); #1;
      bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.shift_src = 32'h0000_0001; bus_if.shift_amt = 5'd20;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("midrst_busy_before", {31'd0, bus_if.busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
      check_eq("midrst_done", {31'd0, bus_if.done}, 32'd0);
      check_eq("midrst_result", bus_if.result, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.busy) done_seen++;
      end
      check_eq("midrst_stays_idle", done_seen, 32'd0);

      run_op("lui", 2'b00, 32'h0000_ABCD, 5'd16, 32'hABCD_0000, 0);
      run_op("sra", 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F, 0);
      run_op("srl", 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F, 0);
      run_op("zero_amt", 2'b01, 32'h1234_5678, 5'd0, 32'h1234_5678, 0);
      run_op("ignored_start", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 3);
`ifdef SHIFT_SEQ_ROR_EN
      run_op("op11", 2'b11, 32'h0000_0003, 5'd1, 32'h8000_0001, 0);
`else
      run_op("op11", 2'b11, 32'h0000_0003, 5'd1, 32'h0000_0003, 0);
`endif

      // Back-to-back: start held high in the done cycle of op A
      @(posedge clk); #1;
      bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.shift_src = 32'h1; bus_if.shift_amt = 5'd3;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("b2b_a_done", {31'd0, bus_if.done}, 32'd1);
      check_eq("b2b_a_result", bus_if.result, 32'h8);
      bus_if.start = 1'b1; bus_if.op = 2'b01; bus_if.shift_src = 32'hFF; bus_if.shift_amt = 5'd4;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      check_eq("b2b_b_busy", {31'd0, bus_if.busy}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("b2b_b_not_yet", {31'd0, bus_if.done}, 32'd0);
      @(posedge clk); #1;
      check_eq("b2b_b_done", {31'd0, bus_if.done}, 32'd1);
      check_eq("b2b_b_result", bus_if.result, 32'h0F);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
